// File: rtl/vga_timing_param_if.sv
// Video timing bundle between the timing generator (master) and the draw stages (slave).
// Optional frame_cnt signal exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_param_if #(
    parameter int CNT_W = 11
);
    logic             pix_en;
    logic             restart;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
`ifdef VGA_TIMING_FRAME_CNT_EN
        output frame_cnt,
`endif
        input  pix_en, restart,
        output hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
`ifdef VGA_TIMING_FRAME_CNT_EN
        input  frame_cnt,
`endif
        output pix_en, restart,
        input  hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with pixel enable, restart, data-enable and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_param #(
    parameter int CNT_W     = 11,
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_param_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_segment
        $error("vga_timing_param: every timing segment must be non-zero");
    end
    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_param: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_POL   = (HSYNC_POL != 0);
    localparam logic             VS_POL   = (VSYNC_POL != 0);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             restart_q, restart_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    // Outputs are decoded from the next counts so they line up with hcount/vcount.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        restart_d     = vif.restart;

        if (vif.restart) begin
            hcount_d      = '0;
            vcount_d      = '0;
            // A held restart strobes only on its first cycle.
            line_start_d  = !restart_q;
            frame_start_d = !restart_q;
        end else if (vif.pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end

        hblnk_d = (hcount_d >= H_ACT_C);
        vblnk_d = (vcount_d >= V_ACT_C);
        hsync_d = ~(((hcount_d >= HS_BEG) && (hcount_d <= HS_END)) ^ HS_POL);
        vsync_d = ~(((vcount_d >= VS_BEG) && (vcount_d <= VS_END)) ^ VS_POL);
        de_d    = !hblnk_d && !vblnk_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            restart_q     <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            restart_q     <= restart_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hblnk       = hblnk_q;
    assign vif.vblnk       = vblnk_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
    assign vif.frame_cnt   = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: three parameterisations checked against a reference model via a scoreboard.
module tb_vga_timing_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_param_if #(.CNT_W(11)) if0 ();
    vga_timing_param_if #(.CNT_W(4))  if1 ();
    vga_timing_param_if #(.CNT_W(11)) if2 ();

    vga_timing_param dut0 (.clk(clk), .rst(rst), .vif(if0.master));

    vga_timing_param #(
        .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut1 (.clk(clk), .rst(rst), .vif(if1.master));

    vga_timing_param #(
        .CNT_W(11), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut2 (.clk(clk), .rst(rst), .vif(if2.master));

    typedef struct packed {
        logic [15:0] fc;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb, vb, hs, vs, de, ls, fs;
    } exp_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
    } tim_t;

    typedef struct {
        bit pe, rs;
        int h, v;
        bit ls, fs;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    cur = 0;
    int    cyc_n = 0;
    string phase = "init";
    tim_t  t;
    int    m_h, m_v, m_fc;
    bit    m_rp;
    exp_t  q[$];
    int    fs_q[$];
    int    ls_q[$];
    exp_t  last_got;
    vec_t  tbl[8];

    function automatic string fmt(exp_t e);
        return $sformatf("h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                         e.h, e.v, e.hb, e.vb, e.hs, e.vs, e.de, e.ls, e.fs, e.fc);
    endfunction

    function automatic exp_t decode(int h, int v, bit ls, bit fs, int fc);
        exp_t e;
        int   hsb = t.ha + t.hf;
        int   vsb = t.va + t.vf;
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hb = (h >= t.ha);
        e.vb = (v >= t.va);
        e.hs = (((h >= hsb) && (h < hsb + t.hs)) == (t.hp != 0));
        e.vs = (((v >= vsb) && (v < vsb + t.vs)) == (t.vp != 0));
        e.de = !e.hb && !e.vb;
        e.ls = ls;
        e.fs = fs;
        e.fc = 16'(fc);
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e = '0;
        case (cur)
            0: begin
                e.h = if0.hcount; e.v = if0.vcount; e.hb = if0.hblnk; e.vb = if0.vblnk;
                e.hs = if0.hsync; e.vs = if0.vsync; e.de = if0.de;
                e.ls = if0.line_start; e.fs = if0.frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
                e.fc = if0.frame_cnt;
`endif
            end
            1: begin
                e.h = 11'(if1.hcount); e.v = 11'(if1.vcount); e.hb = if1.hblnk; e.vb = if1.vblnk;
                e.hs = if1.hsync; e.vs = if1.vsync; e.de = if1.de;
                e.ls = if1.line_start; e.fs = if1.frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
                e.fc = if1.frame_cnt;
`endif
            end
            default: begin
                e.h = if2.hcount; e.v = if2.vcount; e.hb = if2.hblnk; e.vb = if2.vblnk;
                e.hs = if2.hsync; e.vs = if2.vsync; e.de = if2.de;
                e.ls = if2.line_start; e.fs = if2.frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
                e.fc = if2.frame_cnt;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic set_in(input bit pe, input bit rs);
        if0.pix_en = (cur == 0) ? pe : 1'b0;  if0.restart = (cur == 0) ? rs : 1'b0;
        if1.pix_en = (cur == 1) ? pe : 1'b0;  if1.restart = (cur == 1) ? rs : 1'b0;
        if2.pix_en = (cur == 2) ? pe : 1'b0;  if2.restart = (cur == 2) ? rs : 1'b0;
    endtask

    task automatic check_exp(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s cyc=%0d got {%s} expected {%s}", phase, name, cyc_n, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s/%s cyc=%0d got %0d expected %0d", phase, name, cyc_n, got, exp);
        end
    endtask

    // Reference model: advance one clock and queue the expected registered outputs.
    task automatic model_push(input bit pe, input bit rs);
        int ht = t.ha + t.hf + t.hs + t.hb;
        int vt = t.va + t.vf + t.vs + t.vb;
        bit ls = 1'b0;
        bit fs = 1'b0;
        if (rs) begin
            ls = !m_rp;
            fs = !m_rp;
            m_h = 0;
            m_v = 0;
        end else if (pe) begin
            if (m_h == ht - 1) begin
                m_h = 0;
                ls  = 1'b1;
                if (m_v == vt - 1) begin
                    m_v = 0;
                    fs  = 1'b1;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        m_rp = rs;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fs) m_fc = (m_fc + 1) % 65536;
`endif
        q.push_back(decode(m_h, m_v, ls, fs, m_fc));
    endtask

    task automatic cyc(input bit pe, input bit rs);
        exp_t e;
        set_in(pe, rs);
        model_push(pe, rs);
        @(posedge clk);
        #1;
        cyc_n++;
        last_got = sample();
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s/scoreboard_empty cyc=%0d got {%s} expected a queued entry", phase, cyc_n, fmt(last_got));
        end else begin
            e = q.pop_front();
            check_exp("outputs", last_got, e);
        end
        if (!pe && !rs) begin
            checks++;
            if (last_got.ls || last_got.fs) begin
                failures++;
                $display("FAIL %s/strobe_disabled cyc=%0d got ls=%b fs=%b expected 0 0", phase, cyc_n, last_got.ls, last_got.fs);
            end
        end
        if (last_got.fs) fs_q.push_back(cyc_n);
        if (last_got.ls) ls_q.push_back(cyc_n);
    endtask

    // Drops rst between clock edges and checks outputs change without waiting for a clock.
    task automatic do_reset();
        exp_t e;
        set_in(1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        m_h = 0; m_v = 0; m_rp = 1'b0; m_fc = 0;
        q.delete();
        fs_q.delete();
        ls_q.delete();
        e = '0;
        e.de = 1'b1;
        e.hs = (t.hp == 0);
        e.vs = (t.vp == 0);
        check_exp("reset_state", sample(), e);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        tbl[0] = '{pe: 1, rs: 1, h: 0, v: 0, ls: 1, fs: 1};
        tbl[1] = '{pe: 1, rs: 1, h: 0, v: 0, ls: 0, fs: 0};
        tbl[2] = '{pe: 0, rs: 1, h: 0, v: 0, ls: 0, fs: 0};
        tbl[3] = '{pe: 1, rs: 0, h: 1, v: 0, ls: 0, fs: 0};
        tbl[4] = '{pe: 0, rs: 0, h: 1, v: 0, ls: 0, fs: 0};
        tbl[5] = '{pe: 1, rs: 0, h: 2, v: 0, ls: 0, fs: 0};
        tbl[6] = '{pe: 0, rs: 1, h: 0, v: 0, ls: 1, fs: 1};
        tbl[7] = '{pe: 1, rs: 0, h: 1, v: 0, ls: 0, fs: 0};

        set_in(1'b0, 1'b0);

        // Small timing: restart / enable corner vectors.
        cur = 1; phase = "small_table";
        t = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, hp: 1, vp: 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].pe, tbl[i].rs);
            check_int($sformatf("tbl%0d_h", i), int'(last_got.h), tbl[i].h);
            check_int($sformatf("tbl%0d_v", i), int'(last_got.v), tbl[i].v);
            check_int($sformatf("tbl%0d_ls", i), int'(last_got.ls), int'(tbl[i].ls));
            check_int($sformatf("tbl%0d_fs", i), int'(last_got.fs), int'(tbl[i].fs));
        end

        // Small timing, continuous enable: exhaustive over 3 frames plus periods.
        phase = "small_run";
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (i == 195) check_int("frame_cnt_two_frames", int'(last_got.fc), 2);
`endif
        end
        check_int("frame_count", fs_q.size(), 3);
        for (int i = 1; i < fs_q.size(); i++) check_int("frame_period", fs_q[i] - fs_q[i-1], 98);
        for (int i = 1; i < ls_q.size(); i++) check_int("line_period", ls_q[i] - ls_q[i-1], 14);

        // Small timing, enable every other clock.
        phase = "small_toggle";
        do_reset();
        for (int i = 0; i < 600; i++) cyc((i % 2) == 0, 1'b0);
        check_int("frame_count", fs_q.size(), 3);
        for (int i = 1; i < fs_q.size(); i++) check_int("frame_period", fs_q[i] - fs_q[i-1], 196);

        // Default timing: restart mid-line, line wrap, async reset mid-line.
        cur = 0; phase = "default";
        t = '{ha: 800, hf: 40, hs: 128, hb: 88, va: 600, vf: 1, vs: 4, vb: 23, hp: 1, vp: 1};
        do_reset();
        for (int i = 0; i < 500; i++) cyc(1'b1, 1'b0);
        check_int("h_before_restart", int'(last_got.h), 500);
        ls_q.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        check_int("held_restart_strobes", ls_q.size(), 1);
        for (int i = 0; i < 1100; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) cyc((i % 2) == 0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);

        // Inverted polarities with default vertical timing.
        cur = 2; phase = "neg_pol";
        t = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 600, vf: 1, vs: 4, vb: 23, hp: 0, vp: 0};
        do_reset();
        for (int i = 0; i < 8792; i++) cyc(1'b1, 1'b0);
        check_int("frame_count", fs_q.size(), 1);
        for (int i = 0; i < 4205; i++) cyc(1'b1, 1'b0);
        check_int("v_before_restart", int'(last_got.v), 300);
        cyc(1'b0, 1'b1);
        check_int("restart_no_en_h", int'(last_got.h), 0);
        check_int("restart_no_en_v", int'(last_got.v), 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
Parametrised VGA timing generator that replaces the fixed 800x600@40 MHz generator. Every horizontal and vertical timing segment and both sync polarities are set by parameters. Adds a pixel clock-enable, a synchronous restart, a data-enable output and one-cycle line/frame start strobes. Sits at the head of the video pipeline; all draw stages consume its counters and blanking/sync signals.

Parameters:
CNT_W, 11, width of hcount/vcount
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HSYNC_POL, 1, hsync active level (1 = active high)
VSYNC_POL, 1, vsync active level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
pix_en  in  1  pixel clock-enable; counters advance only when high
restart  in  1  synchronous restart to (0,0)
hcount  out  CNT_W  horizontal position
vcount  out  CNT_W  vertical position
hblnk  out  1  horizontal blanking
vblnk  out  1  vertical blanking
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  active video, = !hblnk && !vblnk
line_start  out  1  one-clk strobe on entry to hcount==0
frame_start  out  1  one-clk strobe on entry to (0,0)

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Elaboration $error if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or if any segment is 0.
- Reset (rst low, async) state:
  - hcount=0, vcount=0.
  - hblnk=0, vblnk=0, de=1.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - line_start=0, frame_start=0.
- All outputs are registered. Decode is computed from next-count values, so every output is consistent with hcount/vcount in the same cycle (zero skew).
- Counting, per clk with pix_en=1:
  - hcount increments.
  - At hcount==H_TOTAL-1: hcount→0 and vcount increments.
  - At vcount==V_TOTAL-1 with the same hcount wrap: vcount→0.
- pix_en=0: all counters and decoded outputs hold; strobes deassert.
- restart=1: next clk hcount=0, vcount=0, with line_start=1 and frame_start=1. Restart overrides pix_en. Restart held high keeps counters at (0,0), and the strobes assert only on the first cycle.
- Decode rules:
  - hblnk = (hcount >= H_ACTIVE).
  - hsync active for H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (default 840..967).
  - vblnk = (vcount >= V_ACTIVE).
  - vsync active for V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (default 601..604).
- Strobes:
  - line_start = 1 for exactly one clk, in the cycle hcount becomes 0 through a wrap or restart. It is not asserted for the reset state.
  - frame_start is the same, on entry to (0,0).
- Reset mid-frame: immediate async return to the reset state. Counting resumes from (0,0) on the first clk with rst high and pix_en high.

Optional Feature:
Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0]. Reset value 0. Increments by 1 in the same cycle frame_start asserts; wraps 16'hFFFF→0. Restart also increments it.
- Undefined: port absent; no extra logic.

Test Plan:
- Defaults, pix_en=1 constant:
  - hcount peaks at 1055 and vcount at 627, never exceeded.
  - hblnk=1 exactly for hcount 800..1055; hsync=1 exactly for 840..967.
  - vsync=1 exactly for vcount 601..604.
  - frame_start period is 663168 clk.
- Defaults, pix_en toggled every other clk:
  - Counters change only on enabled cycles.
  - frame_start period is 1326336 clk.
  - No strobe occurs in a pix_en=0 cycle.
- HSYNC_POL=0, VSYNC_POL=0: hsync=0 only for hcount 840..967 and vsync=0 only for vcount 601..604. Reset values are hsync=1, vsync=1.
- Small timing (H 8/2/2/2, V 4/1/1/1; totals 14/7):
  - Exhaustively compare every output against a reference model over 3 frames.
  - Line period 14 clk, frame period 98 clk.
  - de=1 only for hcount<8 and vcount<4.
- Restart asserted at hcount=500, vcount=300:
  - Next clk (0,0) with line_start=1 and frame_start=1.
  - Restart held for 5 clk gives a single strobe.
  - Restart together with pix_en=0 still resets the counters.
- rst pulled low asynchronously between clk edges mid-line: outputs take reset values immediately. With the macro defined, frame_cnt reads 0 after reset and 2 after two full frames.
